// File: rtl/mem_stage_if.sv
// mem_stage_if: M-stage request bundle and MEM/WB writeback bundle.
//   master : pipeline side (drives the M bundle, observes the W bundle)
//   slave  : mem_stage    (consumes the M bundle, drives the W bundle)
interface mem_stage_if #(
  parameter int WIDTH = 32
);
  // M-stage bundle (from the EX/MEM register)
  logic [WIDTH-1:0] ALUResultM;
  logic [1:0]       ResultSrcM;
  logic             MemWriteM;
  logic             RegWriteM;
  logic [WIDTH-1:0] WriteDataM;
  logic [4:0]       RdM;
  logic [WIDTH-1:0] PCPlus4M;
  logic [2:0]       Funct3M;

  // W-stage bundle (MEM/WB register)
  logic [WIDTH-1:0] ALUResultW;
  logic [WIDTH-1:0] ReadDataW;
  logic [1:0]       ResultSrcW;
  logic             RegWriteW;
  logic [4:0]       RdW;
  logic [WIDTH-1:0] PCPlus4W;
  logic             MemErrW;

  modport master (
    output ALUResultM, ResultSrcM, MemWriteM, RegWriteM,
           WriteDataM, RdM, PCPlus4M, Funct3M,
    input  ALUResultW, ReadDataW, ResultSrcW, RegWriteW,
           RdW, PCPlus4W, MemErrW
  );

  modport slave (
    input  ALUResultM, ResultSrcM, MemWriteM, RegWriteM,
           WriteDataM, RdM, PCPlus4M, Funct3M,
    output ALUResultW, ReadDataW, ResultSrcW, RegWriteW,
           RdW, PCPlus4W, MemErrW
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory stage. Word RAM with byte enables, load
// extraction with sign/zero extension, alignment/encoding error detection,
// and the MEM/WB register.
// Ports:
//   CLK  - clock, rising edge
//   RST  - asynchronous active-low reset (clears the W bundle only)
//   bus  - mem_stage_if.slave: M bundle in, W bundle out
module mem_stage #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input logic        CLK,
  input logic        RST,
  mem_stage_if.slave bus
);

  logic [WIDTH-1:0]  mem [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic [1:0]        off;
  logic [WIDTH-1:0]  rword;
  logic [7:0]        bsel;
  logic [15:0]       hsel;
  logic [WIDTH-1:0]  ext;
  logic              active;
  logic              err;
  logic [3:0]        be;
  logic [WIDTH-1:0]  wdat;
  logic              we;

  assign idx    = bus.ALUResultM[ADDR_W+1:2];
  assign off    = bus.ALUResultM[1:0];
  assign rword  = mem[idx];
  assign active = bus.MemWriteM || (bus.ResultSrcM == 2'b01);

  always_comb begin
    case (off)
      2'd0:    bsel = rword[7:0];
      2'd1:    bsel = rword[15:8];
      2'd2:    bsel = rword[23:16];
      default: bsel = rword[31:24];
    endcase
  end

  assign hsel = off[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    case (bus.Funct3M)
      3'b000:  ext = {{24{bsel[7]}}, bsel};
      3'b100:  ext = {24'h0, bsel};
      3'b001:  ext = {{16{hsel[15]}}, hsel};
      3'b101:  ext = {16'h0, hsel};
      default: ext = rword;
    endcase
  end

  // Funct3M[1:0] gives the size (00 B, 01 H, 10 W); the illegal codes
  // 011/110/111 and unsigned store variants are rejected explicitly.
  always_comb begin
    err = 1'b0;
    if (active) begin
      if (bus.Funct3M == 3'b011 || bus.Funct3M == 3'b110 || bus.Funct3M == 3'b111)
        err = 1'b1;
      if (bus.Funct3M[1:0] == 2'b01 && off[0])
        err = 1'b1;
      if (bus.Funct3M[1:0] == 2'b10 && off != 2'b00)
        err = 1'b1;
      if (bus.MemWriteM && bus.Funct3M[2])
        err = 1'b1;
    end
  end

  always_comb begin
    be   = 4'b0000;
    wdat = bus.WriteDataM;
    case (bus.Funct3M[1:0])
      2'b00: begin
        be   = 4'b0001 << off;
        wdat = {4{bus.WriteDataM[7:0]}};
      end
      2'b01: begin
        be   = off[1] ? 4'b1100 : 4'b0011;
        wdat = {2{bus.WriteDataM[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign we = bus.MemWriteM && !err;

  // RAM is never reset; a store is dropped if its edge sees RST low.
  always_ff @(posedge CLK) begin
    if (RST && we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b])
          mem[idx][8*b +: 8] <= wdat[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bus.ALUResultW <= '0;
      bus.ReadDataW  <= '0;
      bus.ResultSrcW <= 2'b00;
      bus.RegWriteW  <= 1'b0;
      bus.RdW        <= 5'd0;
      bus.PCPlus4W   <= '0;
      bus.MemErrW    <= 1'b0;
    end else begin
      bus.ALUResultW <= bus.ALUResultM;
      bus.ReadDataW  <= err ? '0 : ext;
      bus.ResultSrcW <= bus.ResultSrcM;
      bus.RegWriteW  <= bus.RegWriteM && !err;
      bus.RdW        <= bus.RdM;
      bus.PCPlus4W   <= bus.PCPlus4M;
      bus.MemErrW    <= err;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vector table, reset sequences, and randomized
// traffic checked against a byte-array memory model.
module tb_mem_stage;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  mem_stage_if #(.WIDTH(32)) bus ();

  mem_stage #(.WIDTH(32), .DEPTH(256), .ADDR_W(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] mb [1024];

  typedef struct {
    logic        w;
    logic [1:0]  rs;
    logic        rgw;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        exp_regw;
    logic        chk_rd;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t v(logic w, logic [1:0] rs, logic rgw, logic [2:0] f3,
                             logic [31:0] addr, logic [31:0] wd, logic [31:0] exp_rd,
                             logic exp_err, logic exp_regw, logic chk_rd);
    vec_t r;
    r.w = w; r.rs = rs; r.rgw = rgw; r.f3 = f3; r.addr = addr; r.wd = wd;
    r.exp_rd = exp_rd; r.exp_err = exp_err; r.exp_regw = exp_regw; r.chk_rd = chk_rd;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [1:0] rs, input logic rgw,
                       input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rd, input logic [31:0] pc);
    bus.MemWriteM  = w;
    bus.ResultSrcM = rs;
    bus.RegWriteM  = rgw;
    bus.Funct3M    = f3;
    bus.ALUResultM = addr;
    bus.WriteDataM = wd;
    bus.RdM        = rd;
    bus.PCPlus4M   = pc;
  endtask

  task automatic step(input logic w, input logic [1:0] rs, input logic rgw,
                      input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [4:0] rd, input logic [31:0] pc);
    drive(w, rs, rgw, f3, addr, wd, rd, pc);
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ALUResultW"}, bus.ALUResultW, 32'h0);
    chk({tag, ".ReadDataW"},  bus.ReadDataW,  32'h0);
    chk({tag, ".ResultSrcW"}, {30'h0, bus.ResultSrcW}, 32'h0);
    chk({tag, ".RegWriteW"},  {31'h0, bus.RegWriteW}, 32'h0);
    chk({tag, ".RdW"},        {27'h0, bus.RdW}, 32'h0);
    chk({tag, ".PCPlus4W"},   bus.PCPlus4W, 32'h0);
    chk({tag, ".MemErrW"},    {31'h0, bus.MemErrW}, 32'h0);
  endtask

  // Reference model: plain byte-addressed memory, size derived from funct3.
  function automatic logic model_err(logic w, logic [1:0] rs, logic [2:0] f3, logic [1:0] off);
    int size;
    if (!(w || rs == 2'b01)) return 1'b0;
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
    if (w && (f3 == 4 || f3 == 5)) return 1'b1;
    size = (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : 4;
    return (off % size) != 0;
  endfunction

  function automatic logic [31:0] model_load(logic [31:0] addr, logic [2:0] f3);
    int base;
    int off;
    logic [31:0] val;
    base = int'(addr[9:2]) * 4;
    off  = int'(addr[1:0]);
    case (f3)
      3'd0, 3'd4: begin
        val = {24'h0, mb[base + off]};
        if (f3 == 0 && val[7]) val = val | 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        val = {16'h0, mb[base + (off / 2) * 2 + 1], mb[base + (off / 2) * 2]};
        if (f3 == 1 && val[15]) val = val | 32'hFFFF_0000;
      end
      default: val = {mb[base + 3], mb[base + 2], mb[base + 1], mb[base]};
    endcase
    return val;
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd);
    int base;
    int off;
    base = int'(addr[9:2]) * 4;
    off  = int'(addr[1:0]);
    case (f3)
      3'd0: mb[base + off] = wd[7:0];
      3'd1: begin
        mb[base + (off / 2) * 2]     = wd[7:0];
        mb[base + (off / 2) * 2 + 1] = wd[15:8];
      end
      default: for (int k = 0; k < 4; k++) mb[base + k] = wd[8*k +: 8];
    endcase
  endtask

  initial begin
    tbl[0]  = v(1, 2'b00, 0, 3'b010, 32'h10,       32'hDEADBEEF, 32'h0,        0, 0, 0);
    tbl[1]  = v(0, 2'b01, 1, 3'b010, 32'h10,       32'h0,        32'hDEADBEEF, 0, 1, 1);
    tbl[2]  = v(1, 2'b00, 0, 3'b000, 32'h11,       32'h0000007F, 32'h0,        0, 0, 0);
    tbl[3]  = v(0, 2'b01, 1, 3'b010, 32'h10,       32'h0,        32'hDEAD7FEF, 0, 1, 1);
    tbl[4]  = v(1, 2'b00, 0, 3'b001, 32'h12,       32'h00008001, 32'h0,        0, 0, 0);
    tbl[5]  = v(0, 2'b01, 1, 3'b010, 32'h10,       32'h0,        32'h80017FEF, 0, 1, 1);
    tbl[6]  = v(0, 2'b01, 1, 3'b000, 32'h13,       32'h0,        32'hFFFFFF80, 0, 1, 1);
    tbl[7]  = v(0, 2'b01, 1, 3'b100, 32'h13,       32'h0,        32'h00000080, 0, 1, 1);
    tbl[8]  = v(0, 2'b01, 1, 3'b001, 32'h12,       32'h0,        32'hFFFF8001, 0, 1, 1);
    tbl[9]  = v(0, 2'b01, 1, 3'b101, 32'h12,       32'h0,        32'h00008001, 0, 1, 1);
    tbl[10] = v(0, 2'b01, 1, 3'b010, 32'h11,       32'h0,        32'h0,        1, 0, 1);
    tbl[11] = v(1, 2'b00, 0, 3'b001, 32'h13,       32'h0000AAAA, 32'h0,        1, 0, 0);
    tbl[12] = v(0, 2'b01, 1, 3'b010, 32'h10,       32'h0,        32'h80017FEF, 0, 1, 1);
    tbl[13] = v(1, 2'b00, 0, 3'b010, 32'h400,      32'h12345678, 32'h0,        0, 0, 0);
    tbl[14] = v(0, 2'b01, 1, 3'b010, 32'h0,        32'h0,        32'h12345678, 0, 1, 1);
    tbl[15] = v(0, 2'b00, 1, 3'b010, 32'hCAFE0001, 32'h0,        32'h0,        0, 1, 0);
    tbl[16] = v(0, 2'b10, 0, 3'b001, 32'h3,        32'h0,        32'h0,        0, 0, 0);
    tbl[17] = v(0, 2'b01, 1, 3'b011, 32'h0,        32'h0,        32'h0,        1, 0, 1);
    tbl[18] = v(1, 2'b00, 0, 3'b100, 32'h0,        32'hFFFFFFFF, 32'h0,        1, 0, 0);
    tbl[19] = v(1, 2'b00, 0, 3'b111, 32'h0,        32'hFFFFFFFF, 32'h0,        1, 0, 0);
    tbl[20] = v(0, 2'b01, 1, 3'b001, 32'h1,        32'h0,        32'h0,        1, 0, 1);
    tbl[21] = v(0, 2'b01, 1, 3'b010, 32'h0,        32'h0,        32'h12345678, 0, 1, 1);
    tbl[22] = v(0, 2'b01, 1, 3'b100, 32'h1,        32'h0,        32'h00000056, 0, 1, 1);

    // Reset held with arbitrary inputs
    drive(1'b0, 2'b10, 1'b1, 3'b010, 32'hA5A5A5A5, 32'h5A5A5A5A, 5'd7, 32'h44);
    repeat (3) @(posedge CLK);
    #1;
    chk_zero("rst_hold");
    RST = 1'b1;
    step(1'b0, 2'b10, 1'b1, 3'b010, 32'hA5A5A5A5, 32'h0, 5'd7, 32'h44);
    chk("rel.ALUResultW", bus.ALUResultW, 32'hA5A5A5A5);
    chk("rel.RdW",        {27'h0, bus.RdW}, 32'd7);
    chk("rel.PCPlus4W",   bus.PCPlus4W, 32'h44);
    chk("rel.RegWriteW",  {31'h0, bus.RegWriteW}, 32'd1);
    chk("rel.ResultSrcW", {30'h0, bus.ResultSrcW}, 32'd2);

    // Directed vector table
    for (int i = 0; i < 23; i++) begin
      logic [31:0] pc;
      pc = 32'h1000 + 32'(4 * i);
      step(tbl[i].w, tbl[i].rs, tbl[i].rgw, tbl[i].f3, tbl[i].addr, tbl[i].wd, 5'(i), pc);
      chk($sformatf("tbl%0d.ALUResultW", i), bus.ALUResultW, tbl[i].addr);
      chk($sformatf("tbl%0d.ResultSrcW", i), {30'h0, bus.ResultSrcW}, {30'h0, tbl[i].rs});
      chk($sformatf("tbl%0d.RdW", i),        {27'h0, bus.RdW}, 32'(i));
      chk($sformatf("tbl%0d.PCPlus4W", i),   bus.PCPlus4W, pc);
      chk($sformatf("tbl%0d.RegWriteW", i),  {31'h0, bus.RegWriteW}, {31'h0, tbl[i].exp_regw});
      chk($sformatf("tbl%0d.MemErrW", i),    {31'h0, bus.MemErrW}, {31'h0, tbl[i].exp_err});
      if (tbl[i].chk_rd)
        chk($sformatf("tbl%0d.ReadDataW", i), bus.ReadDataW, tbl[i].exp_rd);
    end

    // Store whose edge coincides with reset assertion is dropped
    step(1'b1, 2'b00, 1'b0, 3'b010, 32'h40, 32'h11111111, 5'd1, 32'h8);
    drive(1'b1, 2'b00, 1'b1, 3'b010, 32'h40, 32'h22222222, 5'd2, 32'hC);
    @(negedge CLK);
    #3;
    RST = 1'b0;
    #1;
    chk_zero("rst_async");
    @(posedge CLK);
    #1;
    chk_zero("rst_edge");
    RST = 1'b1;
    step(1'b0, 2'b01, 1'b1, 3'b010, 32'h40, 32'h0, 5'd3, 32'h10);
    chk("rst_store.ReadDataW", bus.ReadDataW, 32'h11111111);
    chk("rst_store.MemErrW",   {31'h0, bus.MemErrW}, 32'd0);

    // Initialise every word so the model and RAM agree everywhere
    for (int i = 0; i < 256; i++) begin
      logic [31:0] d;
      d = $urandom;
      step(1'b1, 2'b00, 1'b0, 3'b010, 32'(i * 4), d, 5'd0, 32'h0);
      model_store(32'(i * 4), 3'b010, d);
    end

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      int          kind;
      logic        w;
      logic [1:0]  rs;
      logic        rgw;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic        e;
      logic [31:0] exp_rd;
      kind = int'($urandom_range(0, 2));
      f3   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0)
        f3 = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(4, 5));
      addr = $urandom;
      wd   = $urandom;
      rd   = 5'($urandom);
      pc   = $urandom;
      rgw  = 1'($urandom);
      w    = (kind == 0);
      rs   = (kind == 1) ? 2'b01 : (($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00);
      if (w) rgw = 1'b0;
      e      = model_err(w, rs, f3, addr[1:0]);
      exp_rd = e ? 32'h0 : model_load(addr, f3);
      step(w, rs, rgw, f3, addr, wd, rd, pc);
      if (w && !e) model_store(addr, f3, wd);
      chk($sformatf("rnd%0d.ALUResultW", n), bus.ALUResultW, addr);
      chk($sformatf("rnd%0d.RdW", n),        {27'h0, bus.RdW}, {27'h0, rd});
      chk($sformatf("rnd%0d.PCPlus4W", n),   bus.PCPlus4W, pc);
      chk($sformatf("rnd%0d.ResultSrcW", n), {30'h0, bus.ResultSrcW}, {30'h0, rs});
      chk($sformatf("rnd%0d.RegWriteW", n),  {31'h0, bus.RegWriteW}, {31'h0, rgw && !e});
      chk($sformatf("rnd%0d.MemErrW", n),    {31'h0, bus.MemErrW}, {31'h0, e});
      if (kind == 1 || e)
        chk($sformatf("rnd%0d.ReadDataW", n), bus.ReadDataW, exp_rd);
      else
        chk($sformatf("rnd%0d.ReadDataW_known", n), {31'h0, ^bus.ReadDataW === 1'bx}, 32'd0);
    end

    // Final sweep: every word matches the model
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 2'b01, 1'b1, 3'b010, 32'(i * 4), 32'h0, 5'd0, 32'h0);
      chk($sformatf("sweep%0d.ReadDataW", i), bus.ReadDataW, model_load(32'(i * 4), 3'b010));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
